// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: streams round keys 0..10 over valid/ready, sharing one external SubWord port.
// Optional AES_KEY_STORE_EN adds an 11-entry round-key store with a combinational read port.

module round_cf (
  input  logic [3:0]  r,
  output logic [31:0] rcon
);
  always_comb begin
    rcon = '0;
    case (r)
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = '0;
    endcase
  end
endmodule

module aes_key_sched_ctrl #(
  parameter int SUB_LAT = 0,
  parameter int NUM_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data
`endif
);

  generate
    if (SUB_LAT != 0 && SUB_LAT != 1) begin : g_bad_lat
      $error("aes_key_sched_ctrl: SUB_LAT must be 0 or 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, OUT, SUB} state_t;
  state_t state;

  logic [3:0]                      nxt_r;
  logic [31:0]                     rcon, t;
  logic [NUM_WORDS-1:0][31:0]      w_cur, w_nxt;
  logic                            hs;

  assign hs    = rk_valid & rk_ready;
  assign nxt_r = rk_round + 4'd1;
  assign w_cur = rk_out;
  assign t     = sub_out ^ rcon;

  round_cf u_rcon (.r(nxt_r), .rcon(rcon));

  // w0 lives in the top word; each following word chains off the freshly computed previous one
  assign w_nxt[NUM_WORDS-1] = w_cur[NUM_WORDS-1] ^ t;
  generate
    for (genvar i = NUM_WORDS-2; i >= 0; i--) begin : g_chain
      assign w_nxt[i] = w_cur[i] ^ w_nxt[i+1];
    end
  endgenerate

  assign sub_in = (state == IDLE) ? 32'h0 : {rk_out[23:0], rk_out[31:24]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_round <= '0;
      rk_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rk_out   <= key_in;
          rk_round <= '0;
          state    <= OUT;
          busy     <= 1'b1;
          rk_valid <= 1'b1;
        end
        OUT: if (hs) begin
          if (rk_round == 4'd10) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b1;
          end else if (SUB_LAT == 0) begin
            rk_out   <= w_nxt;
            rk_round <= nxt_r;
          end else begin
            // registered S-box captures sub_in on this edge; its result is used from SUB
            state    <= SUB;
            rk_valid <= 1'b0;
          end
        end
        SUB: begin
          rk_out   <= w_nxt;
          rk_round <= nxt_r;
          state    <= OUT;
          rk_valid <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [10:0][127:0] store;

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) store <= '0;
    else if (hs) store[rk_round] <= rk_out;
  end

  always_comb begin
    rk_rd_data = '0;
    for (int i = 0; i < 11; i++)
      if (rk_rd_addr == 4'(i)) rk_rd_data = store[i];
  end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: one instance per SUB_LAT setting, FIPS-197 key vectors.
module tb_aes_key_sched_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } vec_t;
  vec_t exp_tbl[11];

  logic [7:0] sbox_t [256];
  int ncmp = 0, nerr = 0, d_sel = 0;

  logic         rst_v[2], start_v[2], rdy_v[2];
  logic [127:0] key_v[2];
  logic         busy0, valid0, done0, busy1, valid1, done1;
  logic [3:0]   rnd0, rnd1;
  logic [127:0] out0, out1;
  logic [31:0]  si0, si1, so0, so1;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rda0, rda1;
  logic [127:0] rdd0, rdd1;
`endif

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  always_comb so0 = subword(si0);
  always @(posedge clk) so1 <= subword(si1);

  aes_key_sched_ctrl #(.SUB_LAT(0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .key_in(key_v[0]), .busy(busy0),
    .rk_valid(valid0), .rk_ready(rdy_v[0]), .rk_round(rnd0), .rk_out(out0), .done(done0),
    .sub_in(si0), .sub_out(so0)
`ifdef AES_KEY_STORE_EN
    , .rk_rd_addr(rda0), .rk_rd_data(rdd0)
`endif
  );

  aes_key_sched_ctrl #(.SUB_LAT(1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .key_in(key_v[1]), .busy(busy1),
    .rk_valid(valid1), .rk_ready(rdy_v[1]), .rk_round(rnd1), .rk_out(out1), .done(done1),
    .sub_in(si1), .sub_out(so1)
`ifdef AES_KEY_STORE_EN
    , .rk_rd_addr(rda1), .rk_rd_data(rdd1)
`endif
  );

  logic         c_busy, c_valid, c_done;
  logic [3:0]   c_round;
  logic [127:0] c_out;
  logic [31:0]  c_si;
  assign c_busy  = d_sel == 1 ? busy1  : busy0;
  assign c_valid = d_sel == 1 ? valid1 : valid0;
  assign c_done  = d_sel == 1 ? done1  : done0;
  assign c_round = d_sel == 1 ? rnd1   : rnd0;
  assign c_out   = d_sel == 1 ? out1   : out0;
  assign c_si    = d_sel == 1 ? si1    : si0;

  localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AKEY = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk_zero(input string tn);
    chk({tn, "_busy"},  c_busy, 0);
    chk({tn, "_valid"}, c_valid, 0);
    chk({tn, "_done"},  c_done, 0);
    chk({tn, "_round"}, c_round, 0);
    chk({tn, "_out"},   c_out, 0);
    chk({tn, "_subin"}, c_si, 0);
  endtask

  // mode: 0 ready held, 1 ready 1-of-3, 2 start injected at round 4, 3 reset at round 6, 4 back-to-back start
  task automatic run(input int d, input int mode, input string tn);
    int idx, cyc, last_acc;
    logic r, pstall;
    logic [127:0] pk;
    d_sel = d;
    @(negedge clk);
    chk({tn, "_idle_busy"}, c_busy, 0);
    start_v[d] = 1; key_v[d] = FKEY; rdy_v[d] = 0;
    @(negedge clk);
    start_v[d] = 0; key_v[d] = '0;
    chk({tn, "_r0_latency"}, c_valid, 1);
    idx = 0; cyc = 0; last_acc = -1; pstall = 0; pk = '0;
    while (idx < 11 && cyc < 200) begin
      if (c_valid) begin
        chk({tn, "_round"}, c_round, exp_tbl[idx].rnd);
        chk({tn, "_key"}, c_out, exp_tbl[idx].key);
        if (pstall) chk({tn, "_stall_hold"}, c_out, pk);
      end
      chk({tn, "_busy"}, c_busy, 1);
      r = (mode == 1) ? (cyc % 3 == 2) : 1'b1;
      if (c_valid && r) begin
        if (mode != 1 && last_acc >= 0) chk({tn, "_gap"}, cyc - last_acc, (d == 1) ? 2 : 1);
        last_acc = cyc;
        idx++;
      end
      pstall = c_valid && !r;
      pk = c_out;
      if (mode == 2 && c_valid && c_round == 4) begin
        start_v[d] = 1; key_v[d] = AKEY;
      end else begin
        start_v[d] = 0; key_v[d] = '0;
      end
      rdy_v[d] = r;
      if (mode == 3 && c_valid && c_round == 6) begin
        rst_v[d] = 1;
        @(negedge clk);
        rst_v[d] = 0; rdy_v[d] = 0;
        chk_zero({tn, "_abort"});
        @(negedge clk);
        chk({tn, "_abort_nodone"}, c_done, 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    rdy_v[d] = 0;
    if (idx < 11) chk({tn, "_timeout"}, idx, 11);
    chk({tn, "_done"}, c_done, 1);
    chk({tn, "_done_busy"}, c_busy, 0);
    chk({tn, "_done_valid"}, c_valid, 0);
    if (mode == 4) begin
      start_v[d] = 1; key_v[d] = AKEY;
      @(negedge clk);
      start_v[d] = 0;
      chk({tn, "_b2b_valid"}, c_valid, 1);
      chk({tn, "_b2b_round"}, c_round, 0);
      chk({tn, "_b2b_key"}, c_out, AKEY);
      rst_v[d] = 1;
      @(negedge clk);
      rst_v[d] = 0;
      chk_zero({tn, "_b2b_rst"});
    end else begin
      @(negedge clk);
      chk({tn, "_done_pulse"}, c_done, 0);
    end
  endtask

  initial begin
    sbox_t = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    exp_tbl[0]  = '{4'd0,  FKEY};
    exp_tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    exp_tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    exp_tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    exp_tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    exp_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    exp_tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    exp_tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    exp_tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    exp_tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    exp_tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1; start_v[i] = 0; rdy_v[i] = 0; key_v[i] = '0;
    end
`ifdef AES_KEY_STORE_EN
    rda0 = '0; rda1 = '0;
`endif
    repeat (2) @(negedge clk);
    start_v[0] = 1; start_v[1] = 1; key_v[0] = AKEY; key_v[1] = AKEY;
    @(negedge clk);
    d_sel = 0; chk_zero("rst0");
    d_sel = 1; chk_zero("rst1");
    rst_v[0] = 0; rst_v[1] = 0; start_v[0] = 0; start_v[1] = 0;

    run(0, 0, "t1");
`ifdef AES_KEY_STORE_EN
    for (int a = 10; a >= 0; a--) begin
      rda0 = 4'(a);
      #1 chk("t6_store", rdd0, exp_tbl[a].key);
    end
    rda0 = 4'd15;
    #1 chk("t6_addr15", rdd0, 0);
`endif
    run(0, 1, "t2");
    run(1, 0, "t3");
    run(0, 2, "t4");
    run(0, 4, "t4b2b");
    run(0, 3, "t5");
    run(0, 0, "t5fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
